// File: rtl/pieo_op_arbiter_if.sv
// Operation-port bundle between the two PIEO requesters, the arbiter and the PIEO queue.
// The master side is the environment (requesters plus PIEO status); the slave side is the arbiter.
interface pieo_op_arbiter_if #(
    parameter int ELEM_W = 40
) ();
    logic              enq_req;
    logic [ELEM_W-1:0] enq_element;
    logic              enq_grant;
    logic              deq_req;
    logic              deq_grant;
    logic              pieo_ready;
    logic              pieo_empty;
    logic              pieo_enq_trigger;
    logic [ELEM_W-1:0] pieo_enq_element;
    logic              pieo_deq_trigger;
    logic              busy;

    modport master (
        output enq_req, enq_element, deq_req, pieo_ready, pieo_empty,
        input  enq_grant, deq_grant, pieo_enq_trigger, pieo_enq_element, pieo_deq_trigger, busy
    );

    modport slave (
        input  enq_req, enq_element, deq_req, pieo_ready, pieo_empty,
        output enq_grant, deq_grant, pieo_enq_trigger, pieo_enq_element, pieo_deq_trigger, busy
    );
endinterface

// File: rtl/pieo_op_arbiter.sv
// Weighted enqueue/dequeue arbiter for the single PIEO operation port, with a dequeue
// starvation guard and a post-trigger gap during which PIEO ready is not trusted.
module pieo_op_arbiter #(
    parameter int ID_LOG       = 4,
    parameter int RANK_LOG     = 4,
    parameter int TIME_LOG     = 32,
    parameter int ENQ_WEIGHT   = 4,
    parameter int STARVE_LIMIT = 16,
    parameter int MIN_GAP      = 2,
    parameter int CNT_WIDTH    = 8
) (
    input logic              clk,
    input logic              rst_n,
    pieo_op_arbiter_if.slave bus
);
    localparam int ELEM_W = ID_LOG + RANK_LOG + TIME_LOG;
    localparam logic [CNT_WIDTH-1:0] WEIGHT_C = CNT_WIDTH'(ENQ_WEIGHT);
    localparam logic [CNT_WIDTH-1:0] STARVE_C = CNT_WIDTH'(STARVE_LIMIT);
    localparam logic [CNT_WIDTH-1:0] GAP_C    = CNT_WIDTH'(MIN_GAP);
    localparam logic [CNT_WIDTH-1:0] ZERO_C   = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] ONE_C    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] SAT_C    = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, WAIT_RDY} state_t;

    state_t               state_r, state_s;
    logic [CNT_WIDTH-1:0] enq_credit_r, credit_s;
    logic [CNT_WIDTH-1:0] starve_cnt_r, starve_s;
    logic [CNT_WIDTH-1:0] gap_cnt_r, gap_s;
    logic                 enq_trig_r, deq_trig_r, busy_r;
    logic [ELEM_W-1:0]    elem_r;
    logic                 grant_enq_s, grant_deq_s;
    logic                 enq_elig_s, deq_elig_s;

    // A dequeue against an empty PIEO is never eligible and so never accrues starvation.
    assign deq_elig_s = bus.deq_req & ~bus.pieo_empty;
    assign enq_elig_s = bus.enq_req;

    // Next-state, arbitration decision and counter updates.
    always_comb begin
        state_s     = state_r;
        grant_enq_s = 1'b0;
        grant_deq_s = 1'b0;
        credit_s    = enq_credit_r;
        starve_s    = starve_cnt_r;
        gap_s       = gap_cnt_r;
        case (state_r)
            IDLE: begin
                if (bus.pieo_ready) begin
                    if (enq_elig_s && deq_elig_s) begin
                        if ((starve_cnt_r >= STARVE_C) || (enq_credit_r == ZERO_C)) begin
                            grant_deq_s = 1'b1;
                        end else begin
                            grant_enq_s = 1'b1;
                            credit_s    = enq_credit_r - ONE_C;
                        end
                    end else begin
                        grant_enq_s = enq_elig_s;
                        grant_deq_s = deq_elig_s;
                    end
                    if (grant_deq_s) begin
                        credit_s = WEIGHT_C;
                        starve_s = ZERO_C;
                    end else if (deq_elig_s && (starve_cnt_r != SAT_C)) begin
                        starve_s = starve_cnt_r + ONE_C;
                    end else begin
                        starve_s = starve_cnt_r;
                    end
                    if (grant_enq_s || grant_deq_s) begin
                        state_s = ISSUE;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                gap_s   = GAP_C;
                state_s = GAP;
            end
            GAP: begin
                // Leave after MIN_GAP cycles; the <= guard keeps a zero load from wrapping.
                if (gap_cnt_r <= ONE_C) begin
                    gap_s   = ZERO_C;
                    state_s = WAIT_RDY;
                end else begin
                    gap_s   = gap_cnt_r - ONE_C;
                    state_s = GAP;
                end
            end
            WAIT_RDY: begin
                if (bus.pieo_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_RDY;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; triggers and grants last exactly the ISSUE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            enq_credit_r <= WEIGHT_C;
            starve_cnt_r <= ZERO_C;
            gap_cnt_r    <= ZERO_C;
            enq_trig_r   <= 1'b0;
            deq_trig_r   <= 1'b0;
            busy_r       <= 1'b0;
            elem_r       <= {ELEM_W{1'b0}};
        end else begin
            state_r      <= state_s;
            enq_credit_r <= credit_s;
            starve_cnt_r <= starve_s;
            gap_cnt_r    <= gap_s;
            enq_trig_r   <= grant_enq_s;
            deq_trig_r   <= grant_deq_s;
            busy_r       <= (state_s != IDLE);
            if (grant_enq_s) begin
                elem_r <= bus.enq_element;
            end
        end
    end

    assign bus.enq_grant        = enq_trig_r;
    assign bus.pieo_enq_trigger = enq_trig_r;
    assign bus.deq_grant        = deq_trig_r;
    assign bus.pieo_deq_trigger = deq_trig_r;
    assign bus.pieo_enq_element = elem_r;
    assign bus.busy             = busy_r;
endmodule

// File: tb/tb_pieo_op_arbiter.sv
// Bench for pieo_op_arbiter: two instances (ordinary weighting, and a tight starvation limit)
// share one stimulus stream and are compared every cycle against an operation-level model.
module tb_pieo_op_arbiter;
    localparam int EW      = 40;
    localparam int CW      = 8;
    localparam int MIN_GAP = 2;
    localparam int WA = 4,   LA = 16;
    localparam int WB = 255, LB = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enq_req = 1'b0, deq_req = 1'b0, pieo_ready = 1'b1, pieo_empty = 1'b0;
    logic [EW-1:0] enq_element = '0;
    int            total = 0, bad = 0;

    always #5 clk = ~clk;

    pieo_op_arbiter_if #(.ELEM_W(EW)) ifa ();
    pieo_op_arbiter_if #(.ELEM_W(EW)) ifb ();

    assign ifa.enq_req = enq_req;  assign ifa.enq_element = enq_element;
    assign ifa.deq_req = deq_req;  assign ifa.pieo_ready  = pieo_ready;
    assign ifa.pieo_empty = pieo_empty;
    assign ifb.enq_req = enq_req;  assign ifb.enq_element = enq_element;
    assign ifb.deq_req = deq_req;  assign ifb.pieo_ready  = pieo_ready;
    assign ifb.pieo_empty = pieo_empty;

    pieo_op_arbiter #(.ID_LOG(4), .RANK_LOG(4), .TIME_LOG(32), .ENQ_WEIGHT(WA), .STARVE_LIMIT(LA),
                      .MIN_GAP(MIN_GAP), .CNT_WIDTH(CW))
        u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    pieo_op_arbiter #(.ID_LOG(4), .RANK_LOG(4), .TIME_LOG(32), .ENQ_WEIGHT(WB), .STARVE_LIMIT(LB),
                      .MIN_GAP(MIN_GAP), .CNT_WIDTH(CW))
        u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Operation-level model: an occupancy window of MIN_GAP+1 cycles after each grant during which
    // PIEO ready is ignored, then the first ready cycle reopens arbitration.
    int            m_w[2], m_l[2], m_hold[2], m_credit[2], m_starve[2];
    bit            m_idle[2], e_enq[2], e_deq[2];
    logic [EW-1:0] e_elem[2];

    task automatic model_step(input int i);
        bit ee, de;
        if (!rst_n) begin
            m_idle[i] = 1'b1; m_hold[i] = 0; m_credit[i] = m_w[i]; m_starve[i] = 0;
            e_enq[i] = 1'b0; e_deq[i] = 1'b0; e_elem[i] = '0;
            return;
        end
        e_enq[i] = 1'b0; e_deq[i] = 1'b0;
        if (m_idle[i]) begin
            if (pieo_ready) begin
                ee = enq_req;
                de = deq_req && !pieo_empty;
                if (ee && de) begin
                    if (m_starve[i] >= m_l[i] || m_credit[i] == 0) e_deq[i] = 1'b1;
                    else begin e_enq[i] = 1'b1; m_credit[i]--; end
                end else begin
                    e_enq[i] = ee; e_deq[i] = de;
                end
                if (e_deq[i]) begin m_credit[i] = m_w[i]; m_starve[i] = 0; end
                else if (de && m_starve[i] < 255) m_starve[i]++;
                if (e_enq[i]) e_elem[i] = enq_element;
                if (e_enq[i] || e_deq[i]) begin m_idle[i] = 1'b0; m_hold[i] = MIN_GAP + 1; end
            end
        end else if (m_hold[i] > 0) m_hold[i]--;
        else if (pieo_ready) m_idle[i] = 1'b1;
    endtask

    task automatic cmp(input int i, input logic eg, dg, et, dt, input logic [EW-1:0] el,
                       input logic bz, input logic [CW-1:0] cr, st);
        string p;
        p = (i == 0) ? "a" : "b";
        chk({p, "_enq_grant"}, eg, e_enq[i]);
        chk({p, "_deq_grant"}, dg, e_deq[i]);
        chk({p, "_enq_trig"},  et, e_enq[i]);
        chk({p, "_deq_trig"},  dt, e_deq[i]);
        chk({p, "_one_trig"},  et & dt, 1'b0);
        chk({p, "_element"},   el, e_elem[i]);
        chk({p, "_busy"},      bz, !m_idle[i]);
        chk({p, "_credit"},    cr, m_credit[i]);
        chk({p, "_starve"},    st, m_starve[i]);
    endtask

    bit          rec_on = 1'b0;
    logic [15:0] ord_a = '0, ord_b = '0;
    int          cnt_a = 0, cnt_b = 0;

    initial begin
        m_w[0] = WA; m_l[0] = LA; m_w[1] = WB; m_l[1] = LB;
        for (int i = 0; i < 2; i++) begin
            m_idle[i] = 1'b1; m_hold[i] = 0; m_credit[i] = m_w[i]; m_starve[i] = 0;
            e_enq[i] = 1'b0; e_deq[i] = 1'b0; e_elem[i] = '0;
        end
    end

    // Per-cycle compare, plus grant-order capture (bit set = dequeue) during the contended phase.
    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        #1;
        cmp(0, ifa.enq_grant, ifa.deq_grant, ifa.pieo_enq_trigger, ifa.pieo_deq_trigger,
            ifa.pieo_enq_element, ifa.busy, u_a.enq_credit_r, u_a.starve_cnt_r);
        cmp(1, ifb.enq_grant, ifb.deq_grant, ifb.pieo_enq_trigger, ifb.pieo_deq_trigger,
            ifb.pieo_enq_element, ifb.busy, u_b.enq_credit_r, u_b.starve_cnt_r);
        if (rec_on && (ifa.enq_grant || ifa.deq_grant) && cnt_a < 16) begin
            ord_a[cnt_a] = ifa.deq_grant; cnt_a++;
        end
        if (rec_on && (ifb.enq_grant || ifb.deq_grant) && cnt_b < 16) begin
            ord_b[cnt_b] = ifb.deq_grant; cnt_b++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        int seen;
        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_busy", ifa.busy, 1'b0);
        chk("rst_enq_trig", ifa.pieo_enq_trigger, 1'b0);
        chk("rst_element", ifa.pieo_enq_element, 40'h0);
        chk("rst_credit_a", u_a.enq_credit_r, 8'd4);
        chk("rst_credit_b", u_b.enq_credit_r, 8'd255);
        rst_n = 1'b1;

        // Idle with ready and no requests.
        repeat (10) @(negedge clk);
        chk("idle_busy", ifa.busy, 1'b0);

        // Single enqueue, then PIEO stays not-ready past the gap.
        enq_req = 1'b1; enq_element = 40'h12_0000_0064;
        @(posedge clk); #2;
        chk("enq_grant_lit", ifa.enq_grant, 1'b1);
        chk("enq_trig_lit", ifa.pieo_enq_trigger, 1'b1);
        chk("enq_elem_lit", ifa.pieo_enq_element, 40'h12_0000_0064);
        chk("enq_busy_lit", ifa.busy, 1'b1);
        @(negedge clk); enq_req = 1'b0; pieo_ready = 1'b0;
        @(posedge clk); #2;
        chk("enq_grant_once", ifa.enq_grant, 1'b0);
        repeat (6) @(negedge clk);
        chk("wait_rdy_busy", ifa.busy, 1'b1);
        pieo_ready = 1'b1;
        @(posedge clk); #2;
        chk("rdy_release_busy", ifa.busy, 1'b0);
        chk("elem_hold", ifa.pieo_enq_element, 40'h12_0000_0064);
        chk("uncontended_credit", u_a.enq_credit_r, 8'd4);

        // Both requests held: weighted order, plus starvation-forced order on instance b.
        @(negedge clk);
        enq_element = 40'ha5_0000_beef; enq_req = 1'b1; deq_req = 1'b1; rec_on = 1'b1;
        for (int n = 0; n < 200 && (cnt_a < 10 || cnt_b < 8); n++) @(negedge clk);
        chk("order_len_a", cnt_a >= 10, 1'b1);
        chk("order_a", ord_a[9:0], 10'h210);
        chk("order_b", ord_b[7:0], 8'h88);

        // Asynchronous reset during an enqueue ISSUE cycle with credit partly spent.
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            @(posedge clk); #2;
            found = ifa.pieo_enq_trigger && (u_a.enq_credit_r != 8'd4);
        end
        chk("found_issue", found, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_enq_trig", ifa.pieo_enq_trigger, 1'b0);
        chk("arst_enq_grant", ifa.enq_grant, 1'b0);
        chk("arst_deq_trig_b", ifb.pieo_deq_trigger | ifb.pieo_enq_trigger, 1'b0);
        enq_req = 1'b0; deq_req = 1'b0; rec_on = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_credit_a", u_a.enq_credit_r, 8'd4);
        chk("arst_starve_a", u_a.starve_cnt_r, 8'd0);
        chk("arst_busy", ifa.busy, 1'b0);
        @(negedge clk);
        chk("arst_no_reissue", ifa.busy, 1'b0);

        // Dequeue against an empty PIEO for 50 cycles while enqueues flow.
        pieo_empty = 1'b1; deq_req = 1'b1; enq_req = 1'b1; seen = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (ifa.deq_grant || ifb.deq_grant) seen++;
        end
        chk("empty_no_deq", seen, 0);
        chk("empty_starve_a", u_a.starve_cnt_r, 8'd0);
        chk("empty_starve_b", u_b.starve_cnt_r, 8'd0);
        chk("empty_credit_a", u_a.enq_credit_r, 8'd4);
        enq_req = 1'b0;
        for (int n = 0; n < 20 && ifa.busy; n++) @(negedge clk);
        chk("drain_busy", ifa.busy, 1'b0);
        pieo_empty = 1'b0;
        @(posedge clk); #2;
        chk("deq_after_empty_a", ifa.deq_grant, 1'b1);
        chk("deq_after_empty_b", ifb.pieo_deq_trigger, 1'b1);
        @(negedge clk); deq_req = 1'b0;

        repeat (8) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
